beep_scheduler: RTL and testbench
=================================

# beep_scheduler

Sound scheduler that shares the board's single piezo tone generator among three sound requesters: game-over jingle, hit effect and jump effect. It latches one-cycle request pulses, grants the highest-priority pending sound, and steps through that sound's fixed note table. For each note it drives a half-period/period word to the downstream square-wave generator, with timed notes and optional silent gaps. It sits between the game FSM and the tone/PWM block.

## Interface
- `NOTE_TICKS`, 12_500_000: clk cycles per note (125 ms at 100 MHz); must be ≥1.
- `GAP_TICKS`, 1_250_000: silent clk cycles between consecutive notes of one sound; 0 means no gap.
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  3  one-cycle request pulses: bit0 game-over, bit1 hit, bit2 jump; index 0 has the highest priority.
- `period`  out  20  tone period in clk cycles for the generator; 0 means silent.
- `busy`  out  1  a sound is being played (NOTE or GAP state).
- `active`  out  2  ID of the sound being played; 0 when idle.
- `done`  out  3  one-cycle pulse on the bit of a sound that completed normally.

## Operation
- **Note tables** (period values):
  - Sound 0 (4 notes): G4=255102, E4=303030, D4=340530, C4=381679.
  - Sound 1 (1 note): A4=227273.
  - Sound 2 (2 notes): C5=191113, D5=170265.
- **Pending register** `pend[2:0]`:
  - `req[i]` sets `pend[i]`. A repeat request while the sound is already pending coalesces into one pending request.
  - `pend[i]` is cleared only on the edge that grants sound `i`. A set and a clear of the same bit on the same edge: the set wins.
  - A request for the sound currently playing sets `pend`, so the sound replays after it finishes.
- **FSM states**: IDLE, NOTE, GAP.
  - **IDLE**: `period`=0, `busy`=0. If `pend`≠0, grant the lowest set index `g`: `active`=g, note index `idx`=0, tick counter `tc`=0, clear `pend[g]`, and go to NOTE.
  - **NOTE**: `period`=table[active][idx], `tc` increments each cycle.
    - When `tc`=NOTE_TICKS-1 and `idx` is the last note: pulse `done[active]`, then go to IDLE with `period`=0, `active`=0.
    - When `tc`=NOTE_TICKS-1 and it is not the last note: go to GAP (or straight to NOTE with `idx`+1 if GAP_TICKS=0), `tc`=0.
  - **GAP**: `period`=0. When `tc`=GAP_TICKS-1: `idx`+1, `tc`=0, go to NOTE.
- **Widths**: `tc` is 24 bits, `idx` is 2 bits. There is no wrap-around: the note-count limit is checked before `idx` is incremented.
- All outputs are registered.

## Timing
- **Reset**: immediate and asynchronous. `period`=0, `busy`=0, `active`=0, `done`=0, `pend`=0, state IDLE. Reset mid-sound silences the output immediately, and a pending request is lost.
- **Request to sound**: `req` sampled at edge k sets `pend` at edge k. The grant happens at edge k+1, where `period`, `busy` and `active` update.
- **Note length**: each note drives `period` for exactly NOTE_TICKS cycles. Each gap lasts exactly GAP_TICKS cycles.
- **Completion**: `done` is high for one cycle, starting on the same edge that returns `period` to 0 and `busy` to 0.
- **Back-to-back**: a minimum of one IDLE cycle separates two consecutive sounds.
- **Simultaneous requests**: when several `req` bits arrive together, the lowest index plays first and the others remain pending in priority order.

## Configuration
- **`BEEP_PREEMPT_EN` defined**: in NOTE or GAP, if any `pend[j]` is set with j < `active`, the next edge switches to j: `active`=j, `idx`=0, `tc`=0, clear `pend[j]`, state NOTE. The aborted sound gets no `done` pulse and is not re-queued.
- **`BEEP_PREEMPT_EN` undefined**: no preemption. A higher-priority request waits in `pend` until the current sound completes.

## Test plan
All scenarios use NOTE_TICKS=4 and GAP_TICKS=2.
- **Reset**: assert `rst` mid-note → `period`=0, `busy`=0, `active`=0 in the same cycle without a clock edge. A `pend` set before reset does not play after release.
- **Single note**: `req`=3'b010 at edge 0 → `period`=227273 after edges 1–4, `busy`=1, `active`=1. After edge 5: `period`=0, `done`=3'b010 for one cycle, `busy`=0.
- **Multi-note sequence**: `req[2]` at edge 0 → sequence 191113 ×4 cycles, 0 ×2, 170265 ×4. `done[2]` pulses after edge 11.
- **Simultaneous requests**: `req`=3'b111 at edge 0 → sound 0 plays first (4 notes, 3 gaps, 22 cycles), one idle cycle, then sound 1, then sound 2. `done` pulses in order bit0, bit1, bit2.
- **Coalescing**: `req[1]` pulsed three times while sound 0 plays → sound 1 plays exactly once afterwards.
- **Preemption**: `req[2]` then `req[0]` during jump note 1.
  - With `BEEP_PREEMPT_EN`: the next edge shows `period`=255102, `active`=0, and `done[2]` never pulses.
  - Without the macro: the jump completes with a `done[2]` pulse, then the game-over sound starts.

Source files
------------

// File: rtl/beep_scheduler.sv
// beep_scheduler
//   Shares the single piezo tone generator among three sound requesters
//   (0 = game-over jingle, 1 = hit effect, 2 = jump effect). One-cycle
//   request pulses are latched into a pending register. The lowest pending
//   index is granted, and that sound's fixed note table is played as timed
//   notes with optional silent gaps between them.
//
// Parameters
//   NOTE_TICKS  clk cycles per note (>= 1)
//   GAP_TICKS   silent clk cycles between notes of one sound (0 = no gap)
//
// Ports
//   clk     in   system clock
//   rst     in   asynchronous, active-high reset
//   req     in   [2:0] one-cycle request pulses, bit 0 has the highest priority
//   period  out  [19:0] tone period in clk cycles, 0 = silent (registered)
//   busy    out  sound playing (NOTE or GAP state) (registered)
//   active  out  [1:0] ID of the sound playing, 0 when idle (registered)
//   done    out  [2:0] one-cycle completion pulse per sound (registered)
//
// Configuration
//   BEEP_PREEMPT_EN  when defined, a pending lower-index sound aborts the
//                    sound currently playing (no done pulse, no re-queue).

module beep_scheduler #(
    parameter int unsigned NOTE_TICKS = 12_500_000,
    parameter int unsigned GAP_TICKS  = 1_250_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    output logic [19:0] period,
    output logic        busy,
    output logic [1:0]  active,
    output logic [2:0]  done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_NOTE,
        S_GAP
    } state_t;

    localparam logic [23:0] NOTE_LAST = 24'(NOTE_TICKS - 1);
    localparam logic [23:0] GAP_LAST  = (GAP_TICKS == 0) ? 24'd0 : 24'(GAP_TICKS - 1);

    state_t      state_q;
    logic [2:0]  pend_q, pend_d;
    logic [23:0] tc_q;
    logic [1:0]  idx_q;
    logic [19:0] period_q;
    logic        busy_q;
    logic [1:0]  active_q;
    logic [2:0]  done_q;

    logic        grant_v;
    logic [1:0]  grant_id;
    logic [2:0]  pend_clr;

    function automatic logic [19:0] note_period(input logic [1:0] snd, input logic [1:0] n);
        logic [19:0] p;
        p = '0;
        case (snd)
            2'd0: begin
                case (n)
                    2'd0:    p = 20'd255102;  // G4
                    2'd1:    p = 20'd303030;  // E4
                    2'd2:    p = 20'd340530;  // D4
                    default: p = 20'd381679;  // C4
                endcase
            end
            2'd1:    p = 20'd227273;          // A4
            2'd2:    p = (n == 2'd0) ? 20'd191113 : 20'd170265;  // C5, D5
            default: p = '0;
        endcase
        return p;
    endfunction

    function automatic logic [1:0] last_idx(input logic [1:0] snd);
        logic [1:0] l;
        case (snd)
            2'd0:    l = 2'd3;
            2'd2:    l = 2'd1;
            default: l = 2'd0;
        endcase
        return l;
    endfunction

    // Grant selection: from IDLE any pending sound; while playing only a
    // strictly higher-priority one, and only when preemption is built in.
    always_comb begin
        grant_v  = 1'b0;
        grant_id = 2'd0;
        if (state_q == S_IDLE) begin
            if (pend_q[0]) begin
                grant_v  = 1'b1;
                grant_id = 2'd0;
            end else if (pend_q[1]) begin
                grant_v  = 1'b1;
                grant_id = 2'd1;
            end else if (pend_q[2]) begin
                grant_v  = 1'b1;
                grant_id = 2'd2;
            end
        end else begin
`ifdef BEEP_PREEMPT_EN
            if (pend_q[0] && (active_q != 2'd0)) begin
                grant_v  = 1'b1;
                grant_id = 2'd0;
            end else if (pend_q[1] && (active_q == 2'd2)) begin
                grant_v  = 1'b1;
                grant_id = 2'd1;
            end
`endif
        end
    end

    // The OR with req comes last so a new request survives its own grant edge.
    always_comb begin
        pend_clr = grant_v ? (3'b001 << grant_id) : 3'b000;
        pend_d   = (pend_q & ~pend_clr) | req;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            pend_q   <= '0;
            tc_q     <= '0;
            idx_q    <= '0;
            period_q <= '0;
            busy_q   <= 1'b0;
            active_q <= '0;
            done_q   <= '0;
        end else begin
            pend_q <= pend_d;
            done_q <= '0;
            if (grant_v) begin
                state_q  <= S_NOTE;
                active_q <= grant_id;
                idx_q    <= '0;
                tc_q     <= '0;
                period_q <= note_period(grant_id, 2'd0);
                busy_q   <= 1'b1;
            end else begin
                case (state_q)
                    S_NOTE: begin
                        if (tc_q == NOTE_LAST) begin
                            tc_q <= '0;
                            if (idx_q == last_idx(active_q)) begin
                                done_q   <= 3'b001 << active_q;
                                state_q  <= S_IDLE;
                                period_q <= '0;
                                busy_q   <= 1'b0;
                                active_q <= '0;
                                idx_q    <= '0;
                            end else if (GAP_TICKS == 0) begin
                                idx_q    <= idx_q + 2'd1;
                                period_q <= note_period(active_q, idx_q + 2'd1);
                            end else begin
                                state_q  <= S_GAP;
                                period_q <= '0;
                            end
                        end else begin
                            tc_q <= tc_q + 24'd1;
                        end
                    end
                    S_GAP: begin
                        if (tc_q == GAP_LAST) begin
                            tc_q     <= '0;
                            idx_q    <= idx_q + 2'd1;
                            state_q  <= S_NOTE;
                            period_q <= note_period(active_q, idx_q + 2'd1);
                        end else begin
                            tc_q <= tc_q + 24'd1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign period = period_q;
    assign busy   = busy_q;
    assign active = active_q;
    assign done   = done_q;

endmodule

// File: tb/tb_beep_scheduler.sv
module tb_beep_scheduler;

    logic        clk;
    logic        rst;
    logic [2:0]  req;
    logic [19:0] period;
    logic        busy;
    logic [1:0]  active;
    logic [2:0]  done;

    int checks;
    int failures;

    typedef struct packed {
        logic [19:0] p;
        logic        b;
        logic [1:0]  a;
        logic [2:0]  d;
    } exp_t;

    exp_t exp_q[$];

    beep_scheduler #(
        .NOTE_TICKS(4),
        .GAP_TICKS (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .period(period),
        .busy  (busy),
        .active(active),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hand-written note tables used to build expected per-edge traces.
    function automatic logic [19:0] tab(input int s, input int n);
        logic [19:0] g0 [4];
        g0[0] = 20'd255102; g0[1] = 20'd303030; g0[2] = 20'd340530; g0[3] = 20'd381679;
        if (s == 0) return g0[n];
        if (s == 1) return 20'd227273;
        return (n == 0) ? 20'd191113 : 20'd170265;
    endfunction

    // Appends the trace of one complete sound starting at its grant edge,
    // ending with the completion edge (which is also the mandatory idle cycle).
    task automatic add_sound(input int s);
        int notes;
        exp_t e;
        notes = (s == 0) ? 4 : (s == 1) ? 1 : 2;
        for (int n = 0; n < notes; n++) begin
            for (int t = 0; t < 4; t++) begin
                e.p = tab(s, n); e.b = 1'b1; e.a = 2'(s); e.d = 3'b000;
                exp_q.push_back(e);
            end
            if (n != notes - 1) begin
                for (int t = 0; t < 2; t++) begin
                    e.p = '0; e.b = 1'b1; e.a = 2'(s); e.d = 3'b000;
                    exp_q.push_back(e);
                end
            end
        end
        e.p = '0; e.b = 1'b0; e.a = 2'd0; e.d = 3'b001 << s;
        exp_q.push_back(e);
    endtask

    task automatic add_idle(input int n);
        exp_t e;
        e = '0;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 3'b000;
        #2;
        checks++;
        if ({period, busy, active, done} !== 26'd0) begin
            failures++;
            $display("FAIL reset_init: got period=%0d busy=%b active=%0d done=%b, want all 0",
                     period, busy, active, done);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        // Play sound 0 with sound 1 left pending, then reset mid-note.
        req = 3'b011;
        tick();
        req = 3'b000;
        tick();
        tick();
        checks++;
        if ({period, busy, active} !== {20'd255102, 1'b1, 2'd0}) begin
            failures++;
            $display("FAIL reset_pre_playing: got period=%0d busy=%b active=%0d, want 255102 1 0",
                     period, busy, active);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({period, busy, active, done} !== 26'd0) begin
            failures++;
            $display("FAIL reset_async: got period=%0d busy=%b active=%0d done=%b, want all 0",
                     period, busy, active, done);
        end
        #2 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if ({period, busy, active, done} !== 26'd0) begin
                failures++;
                $display("FAIL reset_pend_lost[%0d]: got period=%0d busy=%b active=%0d done=%b, want all 0",
                         i, period, busy, active, done);
            end
        end
    endtask

    task automatic test_single_note();
        exp_t got;
        exp_q.delete();
        add_sound(1);
        add_idle(2);
        req = 3'b010;
        tick();
        req = 3'b000;
        checks++;
        if (busy !== 1'b0 || period !== 20'd0) begin
            failures++;
            $display("FAIL single_pend_edge: got busy=%b period=%0d, want 0 0", busy, period);
        end
        foreach (exp_q[i]) begin
            tick();
            got = {period, busy, active, done};
            checks++;
            if (got !== exp_q[i]) begin
                failures++;
                $display("FAIL single_note[%0d]: got p=%0d b=%b a=%0d d=%b, want p=%0d b=%b a=%0d d=%b",
                         i, got.p, got.b, got.a, got.d, exp_q[i].p, exp_q[i].b, exp_q[i].a, exp_q[i].d);
            end
        end
    endtask

    task automatic test_multi_note();
        exp_t got;
        exp_q.delete();
        add_sound(2);
        add_idle(2);
        req = 3'b100;
        tick();
        req = 3'b000;
        foreach (exp_q[i]) begin
            tick();
            got = {period, busy, active, done};
            checks++;
            if (got !== exp_q[i]) begin
                failures++;
                $display("FAIL multi_note[%0d]: got p=%0d b=%b a=%0d d=%b, want p=%0d b=%b a=%0d d=%b",
                         i, got.p, got.b, got.a, got.d, exp_q[i].p, exp_q[i].b, exp_q[i].a, exp_q[i].d);
            end
        end
    endtask

    task automatic test_simultaneous();
        exp_t got;
        exp_q.delete();
        add_sound(0);
        add_sound(1);
        add_sound(2);
        add_idle(2);
        req = 3'b111;
        tick();
        req = 3'b000;
        foreach (exp_q[i]) begin
            tick();
            got = {period, busy, active, done};
            checks++;
            if (got !== exp_q[i]) begin
                failures++;
                $display("FAIL simultaneous[%0d]: got p=%0d b=%b a=%0d d=%b, want p=%0d b=%b a=%0d d=%b",
                         i, got.p, got.b, got.a, got.d, exp_q[i].p, exp_q[i].b, exp_q[i].a, exp_q[i].d);
            end
        end
    endtask

    task automatic test_coalescing();
        exp_t got;
        exp_q.delete();
        add_sound(0);
        add_sound(1);
        add_idle(8);
        req = 3'b001;
        tick();
        req = 3'b000;
        foreach (exp_q[i]) begin
            req = (i == 2 || i == 7 || i == 11) ? 3'b010 : 3'b000;
            tick();
            got = {period, busy, active, done};
            checks++;
            if (got !== exp_q[i]) begin
                failures++;
                $display("FAIL coalescing[%0d]: got p=%0d b=%b a=%0d d=%b, want p=%0d b=%b a=%0d d=%b",
                         i, got.p, got.b, got.a, got.d, exp_q[i].p, exp_q[i].b, exp_q[i].a, exp_q[i].d);
            end
        end
        req = 3'b000;
    endtask

    // A request landing on the very edge that grants the same sound must
    // survive the clear, so the sound plays a second time.
    task automatic test_back_to_back();
        exp_t got;
        exp_q.delete();
        add_sound(1);
        add_sound(1);
        add_idle(3);
        req = 3'b010;
        tick();
        foreach (exp_q[i]) begin
            req = (i == 0) ? 3'b010 : 3'b000;
            tick();
            got = {period, busy, active, done};
            checks++;
            if (got !== exp_q[i]) begin
                failures++;
                $display("FAIL back_to_back[%0d]: got p=%0d b=%b a=%0d d=%b, want p=%0d b=%b a=%0d d=%b",
                         i, got.p, got.b, got.a, got.d, exp_q[i].p, exp_q[i].b, exp_q[i].a, exp_q[i].d);
            end
        end
        req = 3'b000;
    endtask

    task automatic test_preemption();
        exp_t got;
        exp_t e;
        exp_q.delete();
`ifdef BEEP_PREEMPT_EN
        e.p = 20'd191113; e.b = 1'b1; e.a = 2'd2; e.d = 3'b000;
        exp_q.push_back(e);
        exp_q.push_back(e);
        add_sound(0);
`else
        e = '0;
        add_sound(2);
        add_sound(0);
`endif
        add_idle(3);
        req = 3'b100;
        tick();
        foreach (exp_q[i]) begin
            req = (i == 1) ? 3'b001 : 3'b000;
            tick();
            got = {period, busy, active, done};
            checks++;
            if (got !== exp_q[i]) begin
                failures++;
                $display("FAIL preemption[%0d]: got p=%0d b=%b a=%0d d=%b, want p=%0d b=%b a=%0d d=%b",
                         i, got.p, got.b, got.a, got.d, exp_q[i].p, exp_q[i].b, exp_q[i].a, exp_q[i].d);
            end
        end
        req = 3'b000;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        req      = 3'b000;
        test_reset();
        test_single_note();
        test_multi_note();
        test_simultaneous();
        test_coalescing();
        test_back_to_back();
        test_preemption();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
